constraint_eval_seq: RTL and testbench

Streaming, parametrised constraint evaluator for the solver's split-constraint checks. Each accepted input word is tested against NUM_CONSTR runtime-programmable constraints (masked compare against a constant with a selectable relational op). The per-constraint results are reduced to a single verdict `x` through a two-stage valid/ready pipeline, and saturating pass/fail counters are kept alongside. It replaces fixed single-constant combinational checks in the per-split evaluation path.

---
 rtl/constraint_pkg.sv | 20 ++
 rtl/constraint_slot_cmp.sv | 46 ++++
 rtl/constraint_eval_seq.sv | 128 ++++++++++++
 tb/tb_constraint_eval_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/constraint_pkg.sv
// Shared types and helpers for the streaming constraint evaluator.
package constraint_pkg;

    typedef enum logic [2:0] {
        OP_EQ    = 3'd0,
        OP_NE    = 3'd1,
        OP_ULT   = 3'd2,
        OP_ULE   = 3'd3,
        OP_UGT   = 3'd4,
        OP_UGE   = 3'd5,
        OP_TRUE  = 3'd6,
        OP_FALSE = 3'd7
    } op_e;

    // Value a disabled slot contributes so it never sways the reduction.
    function automatic logic reduce_neutral(input logic reduce_or);
        return !reduce_or;
    endfunction

endpackage

// File: rtl/constraint_slot_cmp.sv
// Purpose: one constraint slot, masked relational compare of data against the slot constant.
// Latency: purely combinational.
// Backpressure: none, evaluated every cycle; a disabled slot always yields 0.
module constraint_slot_cmp
    import constraint_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [2*WIDTH+3:0] cfg,
    input  logic [WIDTH-1:0]   data,
    output logic               result
);

    typedef struct packed {
        logic             en;
        op_e              op;
        logic [WIDTH-1:0] cst;
        logic [WIDTH-1:0] mask;
    } slot_cfg_t;

    slot_cfg_t        c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hit;

    assign c = cfg;

    always_comb begin
        a   = data & c.mask;
        b   = c.cst & c.mask;
        hit = 1'b0;
        case (c.op)
            OP_EQ:    hit = (a == b);
            OP_NE:    hit = (a != b);
            OP_ULT:   hit = (a < b);
            OP_ULE:   hit = (a <= b);
            OP_UGT:   hit = (a > b);
            OP_UGE:   hit = (a >= b);
            OP_TRUE:  hit = 1'b1;
            OP_FALSE: hit = 1'b0;
            default:  hit = 1'b0;
        endcase
        result = c.en & hit;
    end

endmodule

// File: rtl/constraint_eval_seq.sv
// Purpose: evaluate each accepted word against NUM_CONSTR programmable slots, reduce to verdict x.
// Latency: 2 cycles acceptance to out_valid (S1 slot results, S2 verdict), 1 word/cycle.
// Backpressure: valid/ready skid of 2 words; in_ready = S1 empty or S2 loading, from out_ready only.
module constraint_eval_seq
    import constraint_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int NUM_CONSTR = 4,
    parameter int REDUCE_OR  = 0,
    parameter int CNT_W      = 16,
    parameter int IDX_W      = (NUM_CONSTR > 1) ? $clog2(NUM_CONSTR) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic                  cfg_en,
    input  logic [2:0]            cfg_op,
    input  logic [WIDTH-1:0]      cfg_const,
    input  logic [WIDTH-1:0]      cfg_mask,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  x,
    output logic [NUM_CONSTR-1:0] constr_bits,
    output logic [CNT_W-1:0]      pass_count,
    output logic [CNT_W-1:0]      fail_count
);

    localparam int   CFG_W  = 2*WIDTH + 4;
    localparam logic RED_OR = (REDUCE_OR != 0);
    localparam logic [IDX_W:0]   SLOT_LIM = (IDX_W+1)'(NUM_CONSTR);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef struct packed {
        logic             en;
        op_e              op;
        logic [WIDTH-1:0] cst;
        logic [WIDTH-1:0] mask;
    } slot_cfg_t;

    localparam slot_cfg_t CFG_RST = '{en: 1'b0, op: OP_EQ, cst: '0, mask: '1};

    slot_cfg_t             cfg_q [NUM_CONSTR];
    logic [NUM_CONSTR-1:0] slot_res;
    logic [NUM_CONSTR-1:0] slot_en;
    logic [NUM_CONSTR-1:0] s1_res;
    logic [NUM_CONSTR-1:0] s1_en;
    logic                  s1_vld;
    logic                  s2_vld;
    logic                  s1_load;
    logic                  s2_load;
    logic                  accept;
    logic                  fire;
    logic                  x_next;

    for (genvar g = 0; g < NUM_CONSTR; g++) begin : g_slot
        constraint_slot_cmp #(.WIDTH(WIDTH)) u_cmp (
            .cfg    (CFG_W'(cfg_q[g])),
            .data   (in_data),
            .result (slot_res[g])
        );
        assign slot_en[g] = cfg_q[g].en;
    end

    // Slot writes land at the clock edge, so a word accepted alongside a write sees the old slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CONSTR; i++) cfg_q[i] <= CFG_RST;
        end else if (cfg_we && ({1'b0, cfg_idx} < SLOT_LIM)) begin
            cfg_q[cfg_idx] <= '{en: cfg_en, op: op_e'(cfg_op), cst: cfg_const, mask: cfg_mask};
        end
    end

    assign s2_load   = !s2_vld || out_ready;
    assign s1_load   = !s1_vld || s2_load;
    assign in_ready  = s1_load;
    assign accept    = in_valid && in_ready;
    assign fire      = s2_vld && out_ready;
    assign out_valid = s2_vld;

    // The enable snapshot travels with the word so later config writes cannot alter its verdict.
    always_comb begin
        x_next = reduce_neutral(RED_OR);
        for (int i = 0; i < NUM_CONSTR; i++) begin
            if (s1_en[i]) x_next = RED_OR ? (x_next | s1_res[i]) : (x_next & s1_res[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld      <= 1'b0;
            s1_res      <= '0;
            s1_en       <= '0;
            s2_vld      <= 1'b0;
            x           <= 1'b0;
            constr_bits <= '0;
        end else begin
            if (s1_load) begin
                s1_vld <= accept;
                if (accept) begin
                    s1_res <= slot_res;
                    s1_en  <= slot_en;
                end
            end
            if (s2_load) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    x           <= x_next;
                    constr_bits <= s1_res;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_count <= '0;
            fail_count <= '0;
        end else if (fire) begin
            if (x && pass_count != CNT_MAX) pass_count <= pass_count + CNT_W'(1);
            if (!x && fail_count != CNT_MAX) fail_count <= fail_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_constraint_eval_seq.sv
// Scoreboard bench: a reference model predicts each verdict at acceptance; a monitor checks deliveries.
module tb_constraint_eval_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic        cfg_en;
    logic [2:0]  cfg_op;
    logic [63:0] cfg_const;
    logic [63:0] cfg_mask;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;

    logic        in_ready,   b_in_ready;
    logic        out_valid,  b_out_valid;
    logic        x,          b_x;
    logic [3:0]  cbits,      b_cbits;
    logic [15:0] pass_count, fail_count;
    logic [1:0]  b_pass,     b_fail;

    constraint_eval_seq #(.WIDTH(64), .NUM_CONSTR(4), .REDUCE_OR(0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_op(cfg_op), .cfg_const(cfg_const), .cfg_mask(cfg_mask),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .x(x), .constr_bits(cbits),
        .pass_count(pass_count), .fail_count(fail_count)
    );

    constraint_eval_seq #(.WIDTH(64), .NUM_CONSTR(4), .REDUCE_OR(0), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_op(cfg_op), .cfg_const(cfg_const), .cfg_mask(cfg_mask),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .x(b_x), .constr_bits(b_cbits),
        .pass_count(b_pass), .fail_count(b_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [2:0]  op;
        logic [63:0] cst;
        logic [63:0] mask;
    } mcfg_t;

    typedef struct {
        logic       x;
        logic [3:0] bits;
        int         cyc;
    } exp_t;

    mcfg_t mcfg [4];
    exp_t  exp_q [$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    m_pass = 0;
    int    m_fail = 0;
    logic  rdy_lock = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model_eval(input logic [63:0] d);
        exp_t        e;
        logic [63:0] a;
        logic [63:0] b;
        logic        r;
        e.x    = 1'b1;
        e.bits = '0;
        e.cyc  = 0;
        for (int i = 0; i < 4; i++) begin
            a = d & mcfg[i].mask;
            b = mcfg[i].cst & mcfg[i].mask;
            case (mcfg[i].op)
                3'd0: r = (a == b);
                3'd1: r = (a != b);
                3'd2: r = (a < b);
                3'd3: r = (a <= b);
                3'd4: r = (a > b);
                3'd5: r = (a >= b);
                3'd6: r = 1'b1;
                default: r = 1'b0;
            endcase
            if (mcfg[i].en) begin
                e.bits[i] = r;
                if (!r) e.x = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mcfg[i] = '{en: 1'b0, op: 3'd0, cst: 64'd0, mask: {64{1'b1}}};
        exp_q.delete();
        m_pass = 0;
        m_fail = 0;
    endtask

    // One clock: sample acceptance/config at the negedge, then land just after the edge.
    task automatic step(output logic acc);
        exp_t e;
        @(negedge clk);
        acc = in_valid && in_ready && !rst;
        if (acc) begin
            e     = model_eval(in_data);
            e.cyc = cyc;
            exp_q.push_back(e);
        end
        if (cfg_we && !rst) mcfg[cfg_idx] = '{en: cfg_en, op: cfg_op, cst: cfg_const, mask: cfg_mask};
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_write(input int idx, input logic en, input int op,
                             input logic [63:0] cst, input logic [63:0] mask);
        logic acc;
        cfg_we    = 1'b1;
        cfg_idx   = 2'(idx);
        cfg_en    = en;
        cfg_op    = 3'(op);
        cfg_const = cst;
        cfg_mask  = mask;
        step(acc);
    endtask

    task automatic send(input logic [63:0] d);
        logic acc;
        int   n = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            step(acc);
            n++;
        end while (!acc && n < 100);
        chk("accept_timeout", {63'd0, acc}, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every delivery; also checks output stability under stall.
    initial begin : monitor
        exp_t       e;
        logic       prev_stall = 1'b0;
        logic       prev_x = 1'b0;
        logic [3:0] prev_bits = '0;
        int         exp_a;
        int         exp_b;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_x", {63'd0, x}, {63'd0, prev_x});
                chk("hold_bits", {60'd0, cbits}, {60'd0, prev_bits});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_verdict", {63'd0, out_valid}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("verdict_x", {63'd0, x}, {63'd0, e.x});
                    chk("constr_bits", {60'd0, cbits}, {60'd0, e.bits});
                    if (rdy_lock) chk("latency", cyc - e.cyc, 2);
                    else if (cyc - e.cyc < 2) chk("latency_min", cyc - e.cyc, 2);
                    exp_a = (m_pass > 65535) ? 65535 : m_pass;
                    chk("pass_count", pass_count, exp_a);
                    exp_a = (m_fail > 65535) ? 65535 : m_fail;
                    chk("fail_count", fail_count, exp_a);
                    exp_b = (m_pass > 3) ? 3 : m_pass;
                    chk("pass_count_w2", b_pass, exp_b);
                    exp_b = (m_fail > 3) ? 3 : m_fail;
                    chk("fail_count_w2", b_fail, exp_b);
                    if (e.x) m_pass++;
                    else m_fail++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_x     = x;
            prev_bits  = cbits;
        end
    end

    initial begin : stimulus
        logic        acc;
        logic [63:0] d;
        int          k;
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_op = '0;
        cfg_const = '0; cfg_mask = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_x", {63'd0, x}, 64'd0);
        chk("rst_bits", {60'd0, cbits}, 64'd0);
        chk("rst_pass", pass_count, 64'd0);
        chk("rst_fail", fail_count, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_lock = 1'b1;

        // Single masked NE slot: equal word fails, zero passes.
        cfg_write(0, 1'b1, 1, 64'h27_6a29_11cf, 64'h7F_FFFF_FFFF);
        send(64'h27_6a29_11cf);
        send(64'h0);
        drain();
        chk("t1_pass", pass_count, 64'd1);
        chk("t1_fail", fail_count, 64'd1);

        // Window check: UGE 0x10 AND ULT 0x20, including both edges.
        cfg_write(0, 1'b1, 5, 64'h10, {64{1'b1}});
        cfg_write(1, 1'b1, 2, 64'h20, {64{1'b1}});
        send(64'h0F);
        send(64'h10);
        send(64'h1F);
        send(64'h20);
        drain();

        // Backpressure: two words buffer, then in_ready drops until out_ready returns.
        rdy_lock  = 1'b0;
        out_ready = 1'b0;
        send(64'h05);
        send(64'h15);
        in_valid = 1'b1;
        in_data  = 64'h25;
        repeat (3) begin
            step(acc);
            chk("bp_no_accept", {63'd0, acc}, 64'd0);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        send(64'h25);
        send(64'h12);
        send(64'h30);
        drain();

        // Config write racing an acceptance: the racing word sees EQ 5, the next one EQ 6.
        rdy_lock = 1'b1;
        cfg_write(1, 1'b0, 0, 64'h0, {64{1'b1}});
        cfg_write(0, 1'b1, 0, 64'h5, {64{1'b1}});
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_en = 1'b1; cfg_op = 3'd0;
        cfg_const = 64'h6; cfg_mask = {64{1'b1}};
        in_valid = 1'b1;
        in_data  = 64'h6;
        step(acc);
        chk("race_accept", {63'd0, acc}, 64'd1);
        in_valid = 1'b0;
        send(64'h6);
        drain();

        // Reset with both stages full drops in-flight words and restores config.
        rdy_lock  = 1'b0;
        out_ready = 1'b0;
        send(64'h6);
        send(64'h7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_pass", pass_count, 64'd0);
        chk("mid_rst_fail", fail_count, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rdy_lock  = 1'b1;
        send(64'h6);

        // Saturation of the narrow counters.
        for (int i = 0; i < 5; i++) send(64'(i * 3 + 1));
        drain();
        chk("sat_pass_w2", b_pass, 64'd3);
        chk("pass_w16", pass_count, 64'd6);

        // Randomized traffic with interleaved config writes and random backpressure.
        rdy_lock = 1'b0;
        acc = 1'b0;
        for (int n = 0; n < 600; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 9) < 7);
                k = $urandom_range(0, 3);
                case ($urandom_range(0, 3))
                    0, 1: d = 64'($urandom_range(0, 40));
                    2:    d = mcfg[k].cst;
                    default: d = {$urandom, $urandom};
                endcase
                in_data = d;
            end
            if ($urandom_range(0, 7) == 0) begin
                cfg_we    = 1'b1;
                cfg_idx   = 2'($urandom_range(0, 3));
                cfg_en    = ($urandom_range(0, 3) != 0);
                cfg_op    = 3'($urandom_range(0, 7));
                cfg_const = ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 31)) : {$urandom, $urandom};
                case ($urandom_range(0, 2))
                    0:       cfg_mask = {64{1'b1}};
                    1:       cfg_mask = 64'h3F;
                    default: cfg_mask = {$urandom, $urandom};
                endcase
            end
            step(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("final_pass", pass_count, (m_pass > 65535) ? 65535 : m_pass);
        chk("final_fail", fail_count, (m_fail > 65535) ? 65535 : m_fail);
        chk("final_pass_w2", b_pass, (m_pass > 3) ? 3 : m_pass);
        chk("final_fail_w2", b_fail, (m_fail > 3) ? 3 : m_fail);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
